ahb_slave_mem: RTL and testbench

- Parametrised AHB-lite slave memory model; successor to the fixed-size, zero-wait bus-model slave.
- Adds configurable data width, depth, base address, programmable wait states, byte/halfword lane writes per hsize, and a single-entry pipelined address/data phase.
- Sits behind the address decoder in the VIP bus-model bench as the default memory target for the AHB master model.

---
 rtl/ahb_slave_mem.sv | 157 +++++++++++++++
 tb/tb_ahb_slave_mem.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ahb_slave_mem.sv
// rtl/ahb_slave_mem.sv - parametrised AHB-lite slave memory: wait states, lane writes, pipelined phases
// Define AHB_SLAVE_MEM_ERROR_RESP_EN to answer illegal transfers with a two-cycle ERROR response.
module ahb_slave_mem #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int DEPTH       = 32,
  parameter int BASE        = 0,
  parameter int WAIT_STATES = 0
) (
  input  logic          hclk,
  input  logic          hreset,
  input  logic          hsel,
  input  logic [AW-1:0] haddr,
  input  logic [1:0]    htrans,
  input  logic [2:0]    hsize,
  input  logic          hwrite,
  input  logic [DW-1:0] hwdata,
  input  logic          hready_i,
  output logic          hready_o,
  output logic          hresp,
  output logic [DW-1:0] hrdata
);

  localparam int NB  = DW / 8;
  localparam int LB  = $clog2(NB);
  localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int AW1 = AW + 1;
  localparam logic [AW:0] LO      = AW1'(BASE);
  localparam logic [AW:0] HI      = AW1'(BASE + DEPTH * NB);
  localparam logic [3:0]  WS_LOAD = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    DATA,
    ERR1,
    ERR2
  } state_t;

  state_t state, state_nx, accept_nx;

  logic [DW-1:0] mem [DEPTH];

  logic [3:0]    cnt;
  logic [IW-1:0] lat_idx;
  logic [LB-1:0] lat_lo;
  logic [2:0]    lat_size;
  logic          lat_write;
  logic          lat_ok;

  logic          trans_active;
  logic          in_range;
  logic          size_ok;
  logic          acc_good;
  logic          accept;
  logic [NB-1:0] lane_mask;

  assign trans_active = (htrans == 2'b10) || (htrans == 2'b11);
  assign in_range     = ({1'b0, haddr} >= LO) && ({1'b0, haddr} < HI);
  assign size_ok      = (hsize <= 3'(LB));

`ifdef AHB_SLAVE_MEM_ERROR_RESP_EN
  logic aligned;
  assign aligned  = (haddr[2:0] & ~(3'b111 << hsize)) == 3'b000;
  assign acc_good = in_range && size_ok && aligned;
`else
  // misaligned in-range accesses are kept and aligned down by the lane mask
  assign acc_good = in_range && size_ok;
`endif

  // stall states hold off the next address phase regardless of hready_i
  assign hready_o = (state != WAIT) && (state != ERR1);
  assign accept   = hsel && hready_i && trans_active && hready_o;

  always_comb begin
    accept_nx = IDLE;
    if (accept) begin
      if (acc_good) begin
        accept_nx = (WAIT_STATES > 0) ? WAIT : DATA;
      end else begin
`ifdef AHB_SLAVE_MEM_ERROR_RESP_EN
        accept_nx = ERR1;
`else
        accept_nx = DATA;
`endif
      end
    end
  end

  always_comb begin
    state_nx = state;
    hresp    = 1'b0;
    hrdata   = '0;
    case (state)
      IDLE: state_nx = accept_nx;
      WAIT: begin
        if (cnt == 4'd0) state_nx = DATA;
      end
      DATA: begin
        state_nx = accept_nx;
        if (!lat_write && lat_ok) hrdata = mem[lat_idx];
      end
`ifdef AHB_SLAVE_MEM_ERROR_RESP_EN
      ERR1: begin
        hresp    = 1'b1;
        state_nx = ERR2;
      end
      ERR2: begin
        hresp    = 1'b1;
        state_nx = accept_nx;
      end
`endif
      default: state_nx = IDLE;
    endcase
  end

  // a byte lane is written when it falls in the same size-aligned group as the latched address
  always_comb begin
    lane_mask = '0;
    for (int b = 0; b < NB; b++) begin
      lane_mask[b] = ((LB'(b) >> lat_size) == (lat_lo >> lat_size));
    end
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_idx   <= '0;
      lat_lo    <= '0;
      lat_size  <= '0;
      lat_write <= 1'b0;
      lat_ok    <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        lat_idx   <= IW'((haddr - AW'(BASE)) >> LB);
        lat_lo    <= haddr[LB-1:0];
        lat_size  <= hsize;
        lat_write <= hwrite;
        lat_ok    <= acc_good;
        cnt       <= WS_LOAD;
      end else if ((state == WAIT) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  always_ff @(posedge hclk) begin
    if ((state == DATA) && lat_write && lat_ok) begin
      for (int b = 0; b < NB; b++) begin
        if (lane_mask[b]) mem[lat_idx][b*8 +: 8] <= hwdata[b*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ahb_slave_mem.sv
// tb/tb_ahb_slave_mem.sv - directed table-driven bench for ahb_slave_mem
// Four instances: DW32 with 0/2/3 wait states and a DW64 zero-wait instance.
module tb_ahb_slave_mem;

`ifdef AHB_SLAVE_MEM_ERROR_RESP_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        hreset = 1'b1;
  logic [3:0]  sel = '0;
  logic [31:0] haddr = '0;
  logic [1:0]  htrans = '0;
  logic [2:0]  hsize = '0;
  logic        hwrite = 1'b0;
  logic [63:0] hwdata = '0;

  logic [3:0]  rdy;
  logic [3:0]  rsp;
  logic [31:0] rd0, rd1, rd2;
  logic [63:0] rd3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ahb_slave_mem #(.AW(32), .DW(32), .DEPTH(32), .BASE(0), .WAIT_STATES(0)) u_ws0 (
    .hclk(clk), .hreset(hreset), .hsel(sel[0]), .haddr(haddr), .htrans(htrans), .hsize(hsize),
    .hwrite(hwrite), .hwdata(hwdata[31:0]), .hready_i(rdy[0]), .hready_o(rdy[0]),
    .hresp(rsp[0]), .hrdata(rd0));

  ahb_slave_mem #(.AW(32), .DW(32), .DEPTH(32), .BASE(0), .WAIT_STATES(2)) u_ws2 (
    .hclk(clk), .hreset(hreset), .hsel(sel[1]), .haddr(haddr), .htrans(htrans), .hsize(hsize),
    .hwrite(hwrite), .hwdata(hwdata[31:0]), .hready_i(rdy[1]), .hready_o(rdy[1]),
    .hresp(rsp[1]), .hrdata(rd1));

  ahb_slave_mem #(.AW(32), .DW(32), .DEPTH(32), .BASE(0), .WAIT_STATES(3)) u_ws3 (
    .hclk(clk), .hreset(hreset), .hsel(sel[2]), .haddr(haddr), .htrans(htrans), .hsize(hsize),
    .hwrite(hwrite), .hwdata(hwdata[31:0]), .hready_i(rdy[2]), .hready_o(rdy[2]),
    .hresp(rsp[2]), .hrdata(rd2));

  ahb_slave_mem #(.AW(32), .DW(64), .DEPTH(32), .BASE(0), .WAIT_STATES(0)) u_dw64 (
    .hclk(clk), .hreset(hreset), .hsel(sel[3]), .haddr(haddr), .htrans(htrans), .hsize(hsize),
    .hwrite(hwrite), .hwdata(hwdata), .hready_i(rdy[3]), .hready_o(rdy[3]),
    .hresp(rsp[3]), .hrdata(rd3));

  typedef struct {
    string       name;
    int          k;
    logic [1:0]  trans;
    logic        wr;
    logic [15:0] addr;
    logic [2:0]  size;
    logic [63:0] wdata;
    logic [63:0] exp_rdata;
    int          exp_stalls;
    logic        exp_resp;
  } vec_t;

  vec_t vq[$];

  function automatic logic [63:0] get_rdata(input int k);
    case (k)
      0: return {32'h0, rd0};
      1: return {32'h0, rd1};
      2: return {32'h0, rd2};
      3: return rd3;
      default: return 64'h0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic add(input string name, input int k, input logic [1:0] trans, input logic wr,
                     input logic [15:0] addr, input logic [2:0] size, input logic [63:0] wdata,
                     input logic [63:0] exp_rdata, input int exp_stalls, input logic exp_resp);
    vec_t v;
    v.name = name; v.k = k; v.trans = trans; v.wr = wr; v.addr = addr; v.size = size;
    v.wdata = wdata; v.exp_rdata = exp_rdata; v.exp_stalls = exp_stalls; v.exp_resp = exp_resp;
    vq.push_back(v);
  endtask

  // single transfer: address phase, then the data phase is followed until hready_o rises
  task automatic xfer(input int k, input logic [1:0] trans, input logic wr, input logic [15:0] addr,
                      input logic [2:0] size, input logic [63:0] wdata, output logic [63:0] rdata,
                      output int stalls, output logic resp_first, output logic resp_last);
    @(posedge clk); #1;
    sel = '0; sel[k] = 1'b1; htrans = trans; haddr = {16'h0, addr}; hwrite = wr; hsize = size;
    @(posedge clk); #1;
    sel = '0; htrans = 2'd0; hwrite = 1'b0; hwdata = wdata;
    @(negedge clk);
    resp_first = rsp[k];
    stalls = 0;
    while (!rdy[k] && stalls < 20) begin
      stalls++;
      @(negedge clk);
    end
    rdata = get_rdata(k);
    resp_last = rsp[k];
  endtask

  initial begin
    logic [63:0] rdata;
    int          stalls;
    logic        rf, rl;

    add("w00",     0, 2'd2, 1, 16'h0000, 3'd2, 64'h55667788, 64'h0, 0, 1'b0);
    add("w20",     0, 2'd2, 1, 16'h0020, 3'd2, 64'hFFFFFFFF, 64'h0, 0, 1'b0);
    add("wb21",    0, 2'd2, 1, 16'h0021, 3'd0, 64'h0000AB00, 64'h0, 0, 1'b0);
    add("r20",     0, 2'd2, 0, 16'h0020, 3'd2, 64'h0, 64'hFFFFABFF, 0, 1'b0);
    add("w30",     0, 2'd2, 1, 16'h0030, 3'd2, 64'h11223344, 64'h0, 0, 1'b0);
    add("wh32",    0, 2'd2, 1, 16'h0032, 3'd1, 64'hBEEF0000, 64'h0, 0, 1'b0);
    add("r30_seq", 0, 2'd3, 0, 16'h0030, 3'd2, 64'h0, 64'hBEEF3344, 0, 1'b0);
    add("w40",     0, 2'd2, 1, 16'h0040, 3'd2, 64'hCAFEF00D, 64'h0, 0, 1'b0);
    add("woor",    0, 2'd2, 1, 16'h0080, 3'd2, 64'hDEADBEEF, 64'h0, ERR ? 1 : 0, ERR);
    add("roor",    0, 2'd2, 0, 16'h0080, 3'd2, 64'h0, 64'h0, ERR ? 1 : 0, ERR);
    add("r00",     0, 2'd2, 0, 16'h0000, 3'd2, 64'h0, 64'h55667788, 0, 1'b0);
    add("rmis02",  0, 2'd2, 0, 16'h0002, 3'd2, 64'h0, ERR ? 64'h0 : 64'h55667788, ERR ? 1 : 0, ERR);
    add("wmis42",  0, 2'd2, 1, 16'h0042, 3'd2, 64'h0, 64'h0, ERR ? 1 : 0, ERR);
    add("r40",     0, 2'd2, 0, 16'h0040, 3'd2, 64'h0, ERR ? 64'hCAFEF00D : 64'h0, 0, 1'b0);
    add("ws2_w04", 1, 2'd2, 1, 16'h0004, 3'd2, 64'h0BADC0DE, 64'h0, 2, 1'b0);
    add("ws2_r04", 1, 2'd2, 0, 16'h0004, 3'd2, 64'h0, 64'h0BADC0DE, 2, 1'b0);
    add("ws2_idle",1, 2'd0, 0, 16'h0004, 3'd2, 64'h0, 64'h0, 0, 1'b0);
    add("ws2_busy",1, 2'd1, 0, 16'h0004, 3'd2, 64'h0, 64'h0, 0, 1'b0);
    add("ws2_oor", 1, 2'd2, 1, 16'h0080, 3'd2, 64'h1, 64'h0, ERR ? 1 : 0, ERR);
    add("ws3_w00", 2, 2'd2, 1, 16'h0000, 3'd2, 64'hA5A5A5A5, 64'h0, 3, 1'b0);
    add("ws3_r00", 2, 2'd2, 0, 16'h0000, 3'd2, 64'h0, 64'hA5A5A5A5, 3, 1'b0);
    add("d64_w08", 3, 2'd2, 1, 16'h0008, 3'd3, 64'h0123456789ABCDEF, 64'h0, 0, 1'b0);
    add("d64_r08", 3, 2'd2, 0, 16'h0008, 3'd3, 64'h0, 64'h0123456789ABCDEF, 0, 1'b0);
    add("d64_wb0d",3, 2'd2, 1, 16'h000D, 3'd0, 64'h00005A0000000000, 64'h0, 0, 1'b0);
    add("d64_r08b",3, 2'd2, 0, 16'h0008, 3'd3, 64'h0, 64'h01235A6789ABCDEF, 0, 1'b0);
    add("d64_roor",3, 2'd2, 0, 16'h0100, 3'd3, 64'h0, 64'h0, ERR ? 1 : 0, ERR);

    repeat (3) @(posedge clk);
    @(negedge clk);
    hreset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("reset_rdy%0d", k), rdy[k], 1'b1);
      chk($sformatf("reset_resp%0d", k), rsp[k], 1'b0);
      chk($sformatf("reset_rdata%0d", k), get_rdata(k), 64'h0);
    end

    // reset asserted during the second stall cycle of a 3-wait-state write
    @(posedge clk); #1;
    sel = 4'b0100; htrans = 2'd2; haddr = 32'h0; hwrite = 1'b1; hsize = 3'd2;
    @(posedge clk); #1;
    sel = '0; htrans = 2'd0; hwrite = 1'b0; hwdata = 64'h11111111;
    @(negedge clk);
    chk("rst_stall1", rdy[2], 1'b0);
    @(posedge clk); #1;
    chk("rst_stall2", rdy[2], 1'b0);
    hreset = 1'b1; #1;
    chk("rst_mid_rdy", rdy[2], 1'b1);
    chk("rst_mid_resp", rsp[2], 1'b0);
    chk("rst_mid_rdata", get_rdata(2), 64'h0);
    @(negedge clk);
    hreset = 1'b0;

    foreach (vq[i]) begin
      xfer(vq[i].k, vq[i].trans, vq[i].wr, vq[i].addr, vq[i].size, vq[i].wdata, rdata, stalls, rf, rl);
      chk($sformatf("%s_rdata", vq[i].name), rdata, vq[i].exp_rdata);
      chk($sformatf("%s_stalls", vq[i].name), 64'(stalls), 64'(vq[i].exp_stalls));
      chk($sformatf("%s_resp1", vq[i].name), rf, vq[i].exp_resp);
      chk($sformatf("%s_resp2", vq[i].name), rl, vq[i].exp_resp);
    end

    // back-to-back write then read of the same word, zero-wait instance
    @(posedge clk); #1;
    sel = 4'b0001; htrans = 2'd2; haddr = 32'h10; hwrite = 1'b1; hsize = 3'd2;
    @(posedge clk); #1;
    htrans = 2'd2; haddr = 32'h10; hwrite = 1'b0; hwdata = 64'h12345678;
    @(negedge clk);
    chk("b2b_rdy_w", rdy[0], 1'b1);
    chk("b2b_rdata_w", get_rdata(0), 64'h0);
    @(posedge clk); #1;
    sel = '0; htrans = 2'd0;
    @(negedge clk);
    chk("b2b_rdy_r", rdy[0], 1'b1);
    chk("b2b_rdata_r", get_rdata(0), 64'h12345678);
    @(posedge clk); #1;
    @(negedge clk);
    chk("b2b_idle_rdata", get_rdata(0), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
